// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one valid/ready data-memory transaction per instruction,
// pipeline stall while outstanding, aligned and extended load data toward MEM/WB.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg_in,
  input  logic [3:0]  memwrite_in,
  input  logic [31:0] ALUout_in,
  input  logic [31:0] rdata2_in,
  input  logic [31:0] inst_data_in,
  input  logic        invalid_in,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_done_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam logic [15:0] TMO  = 16'(TIMEOUT);
  localparam logic [1:0]  SZ_B = 2'd0;
  localparam logic [1:0]  SZ_H = 2'd1;
  localparam logic [1:0]  SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] timer_p1;
  logic [1:0]  addr_lo_p1;
  logic [2:0]  funct3_p1;

  logic        is_store, is_access, misalign, start, reject;
  logic [1:0]  size;
  logic        rsp_done, abort, load_cap;
  logic [15:0] timer_inc;
  logic        unused_inst;

  assign unused_inst = ^{inst_data_in[31:15], inst_data_in[11:0]};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b100:  return {24'b0, b};
      3'b001:  return 32'(h);
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Decode of the live EX/MEM slot; stores win over loads when both are flagged
  always_comb begin
    is_store  = |memwrite_in;
    is_access = reset && !invalid_in && (memtoreg_in || is_store);
    size      = SZ_B;
    if (is_store) begin
      case (memwrite_in)
        4'b0011, 4'b1100: size = SZ_H;
        4'b1111:          size = SZ_W;
        default:          size = SZ_B;
      endcase
    end else begin
      case (inst_data_in[13:12])
        2'b00:   size = SZ_B;
        2'b01:   size = SZ_H;
        default: size = SZ_W;
      endcase
    end
    misalign = ((size == SZ_H) && ALUout_in[0]) || ((size == SZ_W) && (ALUout_in[1:0] != 2'b00));
    start    = (state == IDLE) && is_access && !misalign;
    reject   = (state == IDLE) && is_access && misalign;
  end

  assign timer_inc = sat_inc(timer_p1);

  always_comb begin
    state_nxt = state;
    rsp_done  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (bus_req_ready) begin
          if (bus_rsp_valid) begin
            state_nxt = DONE;
            rsp_done  = 1'b1;
          end else begin
            state_nxt = RSP;
          end
        end else if (timer_inc == TMO) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      RSP: begin
        if (bus_rsp_valid) begin
          state_nxt = DONE;
          rsp_done  = 1'b1;
        end else if (timer_inc == TMO) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    load_cap = rsp_done && !bus_req_we;
  end

  assign stall_out = start || (state == REQ) || (state == RSP);

  // IDLE -> REQ boundary: request fields and extraction selectors latched here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      timer_p1       <= '0;
      bus_req_valid  <= 1'b0;
      bus_req_we     <= 1'b0;
      bus_req_addr   <= '0;
      bus_req_wdata  <= '0;
      bus_req_wstrb  <= '0;
      addr_lo_p1     <= '0;
      funct3_p1      <= '0;
      load_data_out  <= '0;
      load_done_out  <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus_req_valid <= (state_nxt == REQ);
      if (start) begin
        timer_p1      <= '0;
        bus_req_we    <= is_store;
        bus_req_addr  <= {ALUout_in[31:2], 2'b00};
        bus_req_wdata <= is_store ? lane_rep(rdata2_in, size) : 32'd0;
        bus_req_wstrb <= memwrite_in;
        addr_lo_p1    <= ALUout_in[1:0];
        funct3_p1     <= inst_data_in[14:12];
      end else if ((state == REQ) || (state == RSP)) begin
        timer_p1 <= timer_inc;
      end
      load_done_out <= load_cap;
      if (load_cap) load_data_out <= extract(bus_rsp_rdata, addr_lo_p1, funct3_p1);
      bus_err_out    <= abort;
      misaligned_out <= reject;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with a request/load scoreboard, plus hand-written
// timeout and mid-transaction reset sequences.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        memtoreg, invalid, req_ready, rspv, req_valid, req_we, stall, ld_done, mis, err;
  logic [3:0]  memwrite, req_wstrb;
  logic [31:0] alu_addr, rdata2, inst, rsp_rdata, req_addr, req_wdata, ld_data;

  logic        t_memtoreg, t_invalid, t_ready, t_rspv, t_valid, t_we, t_stall, t_ld_done, t_mis, t_err;
  logic [3:0]  t_memwrite, t_wstrb;
  logic [31:0] t_addr, t_inst, t_rdata, t_req_addr, t_wdata, t_ld_data;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .memtoreg_in(memtoreg), .memwrite_in(memwrite),
    .ALUout_in(alu_addr), .rdata2_in(rdata2), .inst_data_in(inst), .invalid_in(invalid),
    .bus_req_valid(req_valid), .bus_req_ready(req_ready), .bus_req_we(req_we),
    .bus_req_addr(req_addr), .bus_req_wdata(req_wdata), .bus_req_wstrb(req_wstrb),
    .bus_rsp_valid(rspv), .bus_rsp_rdata(rsp_rdata), .stall_out(stall),
    .load_data_out(ld_data), .load_done_out(ld_done), .misaligned_out(mis), .bus_err_out(err)
  );

  mem_access_unit #(.TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .memtoreg_in(t_memtoreg), .memwrite_in(t_memwrite),
    .ALUout_in(t_addr), .rdata2_in(rdata2), .inst_data_in(t_inst), .invalid_in(t_invalid),
    .bus_req_valid(t_valid), .bus_req_ready(t_ready), .bus_req_we(t_we),
    .bus_req_addr(t_req_addr), .bus_req_wdata(t_wdata), .bus_req_wstrb(t_wstrb),
    .bus_rsp_valid(t_rspv), .bus_rsp_rdata(t_rdata), .stall_out(t_stall),
    .load_data_out(t_ld_data), .load_done_out(t_ld_done), .misaligned_out(t_mis), .bus_err_out(t_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];

  typedef struct {
    logic        ld;
    logic [3:0]  mask;
    logic        inv;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] inst;
    logic [31:0] rsp;
    int          rdly;
    int          pdly;
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_load;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic clear_main();
    memtoreg = 1'b0; memwrite = 4'h0; invalid = 1'b1; req_ready = 1'b0; rspv = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   stall_cnt = 0;
    int   mis_cnt = 0;
    int   err_cnt = 0;
    int   n = 0;
    int   m = 0;
    bit   acc = 0;
    bit   left = 0;
    int   exp_stall;
    req_t r;
    exp_stall = (v.mis || v.inv) ? 0 : 2 + v.rdly + v.pdly;
    @(posedge clk); #1;
    memtoreg = v.ld; memwrite = v.mask; alu_addr = v.addr; rdata2 = v.wd;
    inst = v.inst; invalid = v.inv; rsp_rdata = v.rsp;
    if (!v.mis && !v.inv) begin
      r.we = (v.mask != 4'h0); r.addr = v.e_addr; r.wdata = v.e_wdata; r.wstrb = v.e_wstrb;
      req_q.push_back(r);
      if (v.ld && v.mask == 4'h0) ld_q.push_back(v.e_load);
    end
    for (int c = 0; c < 40 && !left; c++) begin
      @(negedge clk);
      if (ld_done) begin
        chk($sformatf("v%0d_ld_pending", idx), ld_q.size() != 0, 1);
        if (ld_q.size() != 0) chk($sformatf("v%0d_load_data", idx), ld_data, ld_q.pop_front());
      end
      if (mis) mis_cnt++;
      if (err) err_cnt++;
      if (req_valid) begin
        chk($sformatf("v%0d_req_pending", idx), req_q.size() != 0, 1);
        if (req_q.size() != 0) begin
          chk($sformatf("v%0d_we", idx), req_we, req_q[0].we);
          chk($sformatf("v%0d_addr", idx), req_addr, req_q[0].addr);
          chk($sformatf("v%0d_wdata", idx), req_wdata, req_q[0].wdata);
          chk($sformatf("v%0d_wstrb", idx), req_wstrb, req_q[0].wstrb);
        end
      end
      req_ready = 1'b0; rspv = 1'b0;
      if (req_valid) begin
        n++;
        if (n > v.rdly) begin
          req_ready = 1'b1;
          if (req_q.size() != 0) void'(req_q.pop_front());
          if (v.pdly == 0) rspv = 1'b1;
          else begin acc = 1; m = 0; end
        end
      end else if (acc) begin
        m++;
        if (m == v.pdly) begin rspv = 1'b1; acc = 0; end
      end
      if (stall) stall_cnt++;
      else left = 1;
    end
    chk($sformatf("v%0d_left_mem", idx), left, 1);
    @(posedge clk); #1;
    clear_main();
    repeat (2) begin
      @(negedge clk);
      if (mis) mis_cnt++;
      if (err) err_cnt++;
      if (ld_done) chk($sformatf("v%0d_extra_ld_done", idx), ld_done, 0);
      if (req_valid) chk($sformatf("v%0d_extra_req", idx), req_valid, 0);
    end
    chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, exp_stall);
    chk($sformatf("v%0d_misaligned_pulses", idx), mis_cnt, {31'b0, v.mis});
    chk($sformatf("v%0d_bus_err_pulses", idx), err_cnt, 0);
    chk($sformatf("v%0d_req_left", idx), req_q.size(), 0);
    chk($sformatf("v%0d_ld_left", idx), ld_q.size(), 0);
    req_q.delete();
    ld_q.delete();
  endtask

  task automatic timeout_test();
    int sc = 0;
    int vc = 0;
    bit left = 0;
    // successful best-case load first so a later abort has a value to preserve
    @(posedge clk); #1;
    t_memtoreg = 1'b1; t_memwrite = 4'h0; t_addr = 32'h300; t_inst = 32'h2000; t_invalid = 1'b0;
    t_ready = 1'b1; t_rspv = 1'b1; t_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 10 && !left; c++) begin
      @(negedge clk);
      if (t_stall) sc++;
      else left = 1;
    end
    chk("t_best_left", left, 1);
    chk("t_best_stall", sc, 2);
    chk("t_best_ld_done", t_ld_done, 1);
    chk("t_best_ld_data", t_ld_data, 32'hCAFE_F00D);
    @(posedge clk); #1;
    t_memtoreg = 1'b0; t_invalid = 1'b1; t_ready = 1'b0; t_rspv = 1'b0;
    @(posedge clk); #1;
    t_memtoreg = 1'b1; t_addr = 32'h304; t_invalid = 1'b0;
    sc = 0; left = 0;
    for (int c = 0; c < 30 && !left; c++) begin
      @(negedge clk);
      if (t_valid) vc++;
      if (t_stall) sc++;
      else left = 1;
    end
    chk("t_tmo_left", left, 1);
    chk("t_tmo_req_cycles", vc, 4);
    chk("t_tmo_stall", sc, 5);
    chk("t_tmo_bus_err", t_err, 1);
    chk("t_tmo_ld_done", t_ld_done, 0);
    chk("t_tmo_ld_data_kept", t_ld_data, 32'hCAFE_F00D);
    @(posedge clk); #1;
    t_memtoreg = 1'b0; t_invalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("t_after_bus_err", t_err, 0);
    chk("t_after_stall", t_stall, 0);
    chk("t_after_valid", t_valid, 0);
  endtask

  task automatic reset_test();
    @(posedge clk); #1;
    memtoreg = 1'b1; memwrite = 4'h0; alu_addr = 32'h100; inst = 32'h2000; invalid = 1'b0;
    rsp_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rst_idle_stall", stall, 1);
    req_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", req_valid, 1);
    @(negedge clk);
    req_ready = 1'b0;
    chk("rst_rsp_stall", stall, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_stall", stall, 0);
    chk("rst_async_valid", req_valid, 0);
    chk("rst_async_ld_done", ld_done, 0);
    clear_main();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 rspv = 1'b1;
    @(posedge clk); #1 rspv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_late_ld_done%0d", c), ld_done, 0);
      chk($sformatf("rst_late_ld_data%0d", c), ld_data, 0);
      chk($sformatf("rst_late_stall%0d", c), stall, 0);
    end
  endtask

  initial begin
    //          ld    mask   inv   addr         wd            inst          rsp          rd pd mis   e_addr       e_wdata       e_wstrb e_load
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 32'h103, 32'h0,        32'h0000, 32'h80FF_1234, 0, 1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 4'h0, 1'b0, 32'h102, 32'h0,        32'h5000, 32'h80FF_1234, 0, 0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0000_80FF};
    vecs[2]  = '{1'b1, 4'h0, 1'b0, 32'h102, 32'h0,        32'h1000, 32'h80FF_1234, 1, 2, 1'b0, 32'h100, 32'h0,        4'h0, 32'hFFFF_80FF};
    vecs[3]  = '{1'b1, 4'h0, 1'b0, 32'h100, 32'h0,        32'h2000, 32'h80FF_1234, 0, 1, 1'b0, 32'h100, 32'h0,        4'h0, 32'h80FF_1234};
    vecs[4]  = '{1'b1, 4'h0, 1'b0, 32'h101, 32'h0,        32'h4000, 32'h80FF_1234, 0, 1, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0000_0012};
    vecs[5]  = '{1'b1, 4'h0, 1'b0, 32'h100, 32'h0,        32'h0000, 32'h80FF_1234, 2, 0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0000_0034};
    vecs[6]  = '{1'b0, 4'h4, 1'b0, 32'h206, 32'h0000_00AB, 32'h0000, 32'h0,        3, 1, 1'b0, 32'h204, 32'hABAB_ABAB, 4'h4, 32'h0};
    vecs[7]  = '{1'b0, 4'hC, 1'b0, 32'h20A, 32'h1234_BEEF, 32'h0000, 32'h0,        0, 1, 1'b0, 32'h208, 32'hBEEF_BEEF, 4'hC, 32'h0};
    vecs[8]  = '{1'b0, 4'hF, 1'b0, 32'h20C, 32'hDEAD_BEEF, 32'h0000, 32'h0,        1, 0, 1'b0, 32'h20C, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 4'h0, 1'b0, 32'h101, 32'h0,        32'h2000, 32'h0,        0, 1, 1'b1, 32'h0,   32'h0,        4'h0, 32'h0};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 32'h103, 32'h0,        32'h1000, 32'h0,        0, 1, 1'b1, 32'h0,   32'h0,        4'h0, 32'h0};
    vecs[11] = '{1'b0, 4'h3, 1'b0, 32'h201, 32'h0000_5678, 32'h0000, 32'h0,        0, 1, 1'b1, 32'h0,   32'h0,        4'h0, 32'h0};
    vecs[12] = '{1'b0, 4'hF, 1'b0, 32'h202, 32'h0000_5678, 32'h0000, 32'h0,        0, 1, 1'b1, 32'h0,   32'h0,        4'h0, 32'h0};
    vecs[13] = '{1'b1, 4'h0, 1'b1, 32'h100, 32'h0,        32'h2000, 32'h0,        0, 1, 1'b0, 32'h0,   32'h0,        4'h0, 32'h0};
    vecs[14] = '{1'b1, 4'h0, 1'b0, 32'h104, 32'h0,        32'h7000, 32'h80FF_1234, 0, 1, 1'b0, 32'h104, 32'h0,        4'h0, 32'h80FF_1234};
    vecs[15] = '{1'b1, 4'h1, 1'b0, 32'h210, 32'h0000_0055, 32'h0000, 32'h0,        0, 1, 1'b0, 32'h210, 32'h5555_5555, 4'h1, 32'h0};
    vecs[16] = '{1'b1, 4'h0, 1'b0, 32'h100, 32'h0,        32'h1000, 32'h80FF_1234, 0, 2, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0000_1234};

    reset = 1'b0;
    memtoreg = 1'b1; memwrite = 4'h0; alu_addr = 32'h100; rdata2 = 32'h0; inst = 32'h2000;
    invalid = 1'b0; req_ready = 1'b0; rspv = 1'b0; rsp_rdata = 32'h0;
    t_memtoreg = 1'b0; t_memwrite = 4'h0; t_addr = 32'h0; t_inst = 32'h0; t_invalid = 1'b1;
    t_ready = 1'b0; t_rspv = 1'b0; t_rdata = 32'h0;
    #12;
    chk("reset_stall_gated", stall, 0);
    chk("reset_req_valid", req_valid, 0);
    chk("reset_req_we", req_we, 0);
    chk("reset_req_addr", req_addr, 0);
    chk("reset_req_wdata", req_wdata, 0);
    chk("reset_req_wstrb", req_wstrb, 0);
    chk("reset_load_data", ld_data, 0);
    chk("reset_load_done", ld_done, 0);
    chk("reset_misaligned", mis, 0);
    chk("reset_bus_err", err, 0);
    clear_main();
    @(negedge clk);
    reset = 1'b1;

    timeout_test();
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);
    reset_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
